// File: rtl/tlc_pkg.sv
// -----------------------------------------------------------------------------
// tlc_pkg
// Shared types and constants for the intersection phase scheduler.
//   - tlc_state_t : phase state encoding (all-red clearance, green, yellow)
//   - DEF_*       : default timing constants, in tick units
//   - clog2()     : ceiling log2 usable in constant expressions
// Optional feature macro used by the scheduler: EMERGENCY_PREEMPT_EN.
// -----------------------------------------------------------------------------
package tlc_pkg;

  typedef enum logic [1:0] {
    ST_ALL_RED = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2
  } tlc_state_t;

  localparam int DEF_N_APPR    = 4;
  localparam int DEF_MIN_GREEN = 8;
  localparam int DEF_MAX_GREEN = 32;
  localparam int DEF_YELLOW_T  = 4;
  localparam int DEF_ALL_RED_T = 2;
  localparam int DEF_WALK_T    = 6;
  localparam int DEF_CW        = 6;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. The search starts at (last+1) mod N and
// wraps; the first requesting index wins. The pointer lives in the parent.
// Ports:
//   req       in  N   request vector
//   last      in  IW  index served most recently
//   grant     out N   one-hot grant (zero when req is zero)
//   grant_idx out IW  index of the granted bit (last when req is zero)
// -----------------------------------------------------------------------------
module rr_arbiter
  import tlc_pkg::*;
#(
  parameter int  N  = 4,
  localparam int IW = clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  // One spare bit so last+i cannot overflow before the wrap subtraction.
  localparam int SW = IW + 1;

  logic [SW-1:0] cand_sum;
  logic [IW-1:0] cand_idx;
  logic          found;

  always_comb begin
    grant     = '0;
    grant_idx = last;
    found     = 1'b0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int i = 1; i <= N; i++) begin
      cand_sum = {1'b0, last} + SW'(i);
      if (cand_sum >= SW'(N)) cand_sum = cand_sum - SW'(N);
      cand_idx = cand_sum[IW-1:0];
      if (!found && req[cand_idx]) begin
        found           = 1'b1;
        grant[cand_idx] = 1'b1;
        grant_idx       = cand_idx;
      end
    end
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_phase_scheduler
// Grants one approach green at a time, cycling GREEN -> YELLOW -> ALL_RED with
// min-green, gap-out, max-out and walk timing. All timers advance only on tick.
// Ports:
//   clk, reset (async, active-high), tick (1-cycle timing enable)
//   veh_req[N]   level vehicle presence      ped_req[N] pedestrian pulses
//   green[N]     one-hot or zero green       yellow[N]  one-hot or zero yellow
//   all_red      high in the ALL_RED state   ped_walk[N] walk (subset of green)
//   phase_idx    current / last-served index ped_pend[N] latched ped requests
// Optional: define EMERGENCY_PREEMPT_EN to add preempt / preempt_idx inputs.
// -----------------------------------------------------------------------------
module intersection_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int  N_APPR    = DEF_N_APPR,
  parameter int  MIN_GREEN = DEF_MIN_GREEN,
  parameter int  MAX_GREEN = DEF_MAX_GREEN,
  parameter int  YELLOW_T  = DEF_YELLOW_T,
  parameter int  ALL_RED_T = DEF_ALL_RED_T,
  parameter int  WALK_T    = DEF_WALK_T,
  parameter int  CW        = DEF_CW,
  localparam int IW        = clog2(N_APPR)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic [N_APPR-1:0] veh_req,
  input  logic [N_APPR-1:0] ped_req,
`ifdef EMERGENCY_PREEMPT_EN
  input  logic              preempt,
  input  logic [IW-1:0]     preempt_idx,
`endif
  output logic [N_APPR-1:0] green,
  output logic [N_APPR-1:0] yellow,
  output logic              all_red,
  output logic [N_APPR-1:0] ped_walk,
  output logic [IW-1:0]     phase_idx,
  output logic [N_APPR-1:0] ped_pend
);

  localparam int EW = CW + 1;

  tlc_state_t        state_reg;
  logic [CW-1:0]     timer_reg;
  logic [CW-1:0]     green_cnt_reg;
  logic [IW-1:0]     last_reg;
  logic [N_APPR-1:0] green_reg, yellow_reg, walk_reg, pend_reg;
  logic              all_red_reg;
  logic [IW-1:0]     idx_reg;

  logic [N_APPR-1:0] req, arb_grant, win_grant, pend_clr, pend_next;
  logic [IW-1:0]     arb_idx, win_idx;
  logic [EW-1:0]     elapsed;
  logic [CW-1:0]     green_cnt_next;
  logic              win_valid, timer_expired, others_req, cur_veh;
  logic              to_yellow, walk_drop, enter_green;

  assign req           = veh_req | pend_reg;
  assign timer_expired = (timer_reg <= CW'(1));
  // Green ticks including the one currently being applied.
  assign elapsed       = {1'b0, green_cnt_reg} + EW'(1);
  assign others_req    = |(req & ~green_reg);
  assign cur_veh       = |(veh_req & green_reg);

  rr_arbiter #(.N(N_APPR)) u_arb (
    .req       (req),
    .last      (last_reg),
    .grant     (arb_grant),
    .grant_idx (arb_idx)
  );

  always_comb begin
    win_grant      = arb_grant;
    win_idx        = arb_idx;
    win_valid      = |req;
    green_cnt_next = (elapsed >= EW'(MAX_GREEN)) ? CW'(MAX_GREEN) : elapsed[CW-1:0];
    to_yellow      = others_req &&
                     ((!cur_veh && elapsed >= EW'(MIN_GREEN)) ||
                      ( cur_veh && elapsed >= EW'(MAX_GREEN)));
    walk_drop      = (elapsed >= EW'(WALK_T));
`ifdef EMERGENCY_PREEMPT_EN
    if (preempt) begin
      win_grant              = '0;
      win_grant[preempt_idx] = 1'b1;
      win_idx                = preempt_idx;
      win_valid              = 1'b1;
      if (green_reg[preempt_idx]) begin
        // Hold; bank min-green so release can gap/max out normally.
        to_yellow = 1'b0;
        if (elapsed < EW'(MIN_GREEN)) green_cnt_next = CW'(MIN_GREEN);
      end else begin
        to_yellow = 1'b1;
        walk_drop = 1'b1;
      end
    end
`endif
    enter_green = tick && (state_reg == ST_ALL_RED) && timer_expired && win_valid;
    pend_clr    = enter_green ? (win_grant & pend_reg) : '0;
    // A new button press on the same edge as the clear survives.
    pend_next   = (pend_reg & ~pend_clr) | ped_req;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_ALL_RED;
      timer_reg     <= CW'(ALL_RED_T);
      green_cnt_reg <= '0;
      last_reg      <= IW'(N_APPR - 1);
      idx_reg       <= IW'(N_APPR - 1);
      green_reg     <= '0;
      yellow_reg    <= '0;
      walk_reg      <= '0;
      pend_reg      <= '0;
      all_red_reg   <= 1'b1;
    end else begin
      pend_reg <= pend_next;
      if (tick) begin
        case (state_reg)
          ST_ALL_RED: begin
            if (enter_green) begin
              state_reg     <= ST_GREEN;
              all_red_reg   <= 1'b0;
              green_reg     <= win_grant;
              walk_reg      <= win_grant & pend_reg;
              idx_reg       <= win_idx;
              last_reg      <= win_idx;
              green_cnt_reg <= '0;
            end else if (timer_expired) begin
              timer_reg <= '0;  // resting: any later tick with a request enters green
            end else begin
              timer_reg <= timer_reg - CW'(1);
            end
          end
          ST_GREEN: begin
            green_cnt_reg <= green_cnt_next;
            if (to_yellow) begin
              state_reg  <= ST_YELLOW;
              yellow_reg <= green_reg;
              green_reg  <= '0;
              walk_reg   <= '0;
              timer_reg  <= CW'(YELLOW_T);
            end else if (walk_drop) begin
              walk_reg <= '0;
            end
          end
          ST_YELLOW: begin
            if (timer_expired) begin
              state_reg   <= ST_ALL_RED;
              yellow_reg  <= '0;
              all_red_reg <= 1'b1;
              timer_reg   <= CW'(ALL_RED_T);
            end else begin
              timer_reg <= timer_reg - CW'(1);
            end
          end
          default: state_reg <= ST_ALL_RED;
        endcase
      end
    end
  end

  assign green     = green_reg;
  assign yellow    = yellow_reg;
  assign all_red   = all_red_reg;
  assign ped_walk  = walk_reg;
  assign phase_idx = idx_reg;
  assign ped_pend  = pend_reg;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// -----------------------------------------------------------------------------
// tb_intersection_phase_scheduler
// Directed bench for intersection_phase_scheduler with default parameters.
// Expected lamp states are queued before each stimulus step and popped and
// compared on the following negedge. Covers EMERGENCY_PREEMPT_EN only by tying
// its inputs inactive when the macro is defined.
// -----------------------------------------------------------------------------
module tb_intersection_phase_scheduler;

  logic       clk = 1'b0;
  logic       reset;
  logic       tick;
  logic [3:0] veh_req, ped_req;
  logic [3:0] green, yellow, ped_walk, ped_pend;
  logic       all_red;
  logic [1:0] phase_idx;

  always #5 clk = ~clk;

  intersection_phase_scheduler dut (
    .clk       (clk),
    .reset     (reset),
    .tick      (tick),
    .veh_req   (veh_req),
    .ped_req   (ped_req),
`ifdef EMERGENCY_PREEMPT_EN
    .preempt     (1'b0),
    .preempt_idx (2'd0),
`endif
    .green     (green),
    .yellow    (yellow),
    .all_red   (all_red),
    .ped_walk  (ped_walk),
    .phase_idx (phase_idx),
    .ped_pend  (ped_pend)
  );

  typedef struct {
    string       tag;
    logic [18:0] exp;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_o(input string tag, input logic [3:0] g, input logic [3:0] y,
                          input logic ar, input logic [3:0] pw, input logic [3:0] pp,
                          input logic [1:0] idx);
    exp_t e;
    e.tag = tag;
    e.exp = {g, y, ar, pw, pp, idx};
    sb.push_back(e);
  endtask

  task automatic check_o();
    exp_t        e;
    logic [18:0] obs;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed no entry required one entry");
      return;
    end
    e   = sb.pop_front();
    obs = {green, yellow, all_red, ped_walk, ped_pend, phase_idx};
    assert (obs === e.exp) else begin
      n_fail++;
      $error("FAIL %s: observed g=%b y=%b ar=%b pw=%b pp=%b idx=%0d required g=%b y=%b ar=%b pw=%b pp=%b idx=%0d",
             e.tag, green, yellow, all_red, ped_walk, ped_pend, phase_idx,
             e.exp[18:15], e.exp[14:11], e.exp[10], e.exp[9:6], e.exp[5:2], e.exp[1:0]);
    end
    n_assert++;
    assert (!((|green) && (|yellow)) && $onehot0(green) && $onehot0(yellow) &&
            ((ped_walk & ~green) == 4'b0)) else begin
      n_fail++;
      $error("FAIL invariant_%s: observed g=%b y=%b pw=%b required exclusive one-hot lamps, walk within green",
             e.tag, green, yellow, ped_walk);
    end
    $display("[%0t] %s g=%b y=%b ar=%b pw=%b pp=%b idx=%0d", $time, e.tag,
             green, yellow, all_red, ped_walk, ped_pend, phase_idx);
  endtask

  // Queue the expectation, advance n cycles, compare.
  task automatic step(input int n, input string tag, input logic [3:0] g, input logic [3:0] y,
                      input logic ar, input logic [3:0] pw, input logic [3:0] pp,
                      input logic [1:0] idx);
    expect_o(tag, g, y, ar, pw, pp, idx);
    cyc(n);
    check_o();
  endtask

  initial begin
    reset   = 1'b1;
    tick    = 1'b1;
    veh_req = 4'b0010;
    ped_req = 4'b0000;

    // Reset state and first service of approach 1, then rest in green.
    step(1, "reset_state", 4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd3);
    reset = 1'b0;
    step(1,  "allred_tick1",  4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd3);
    step(1,  "green_appr1",   4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd1);
    step(40, "rest_green",    4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd1);

    // Max-out: both approaches hold requests.
    reset = 1'b1; veh_req = 4'b0011; cyc(1); reset = 1'b0;
    step(2,  "mo_green0",     4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);
    step(31, "mo_green31",    4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);
    step(1,  "mo_yellow",     4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 2'd0);
    step(3,  "mo_yellow4",    4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 2'd0);
    step(1,  "mo_allred",     4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0);
    step(1,  "mo_allred2",    4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd0);
    step(1,  "mo_green1",     4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd1);

    // Min-green boundary: own request gone right after entry.
    reset = 1'b1; veh_req = 4'b0011; cyc(1); reset = 1'b0;
    step(2,  "mg_green0",     4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);
    veh_req = 4'b0010;
    step(7,  "mg_hold7",      4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);
    step(1,  "mg_yellow8",    4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 2'd0);

    // Gap-out after min-green: bit 0 drops at green tick 10.
    reset = 1'b1; veh_req = 4'b0011; cyc(1); reset = 1'b0;
    step(2,  "go_green0",     4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);
    step(10, "go_green10",    4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);
    veh_req = 4'b0010;
    step(1,  "go_yellow",     4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0000, 2'd0);

    // Pedestrian latch and walk on approach 2.
    reset = 1'b1; veh_req = 4'b0001; cyc(1); reset = 1'b0;
    step(2,  "pd_green0",     4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);
    cyc(3);
    ped_req = 4'b0100; veh_req = 4'b0000;
    step(1,  "pd_latched",    4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0100, 2'd0);
    ped_req = 4'b0000;
    step(3,  "pd_green7",     4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0100, 2'd0);
    step(1,  "pd_yellow",     4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b0100, 2'd0);
    step(4,  "pd_allred",     4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0100, 2'd0);
    cyc(1);
    ped_req = 4'b0100;  // press coincides with the clearing entry edge
    step(1,  "pd_walk_entry", 4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 2'd2);
    ped_req = 4'b0000;
    step(5,  "pd_walk5",      4'b0100, 4'b0000, 1'b0, 4'b0100, 4'b0100, 2'd2);
    step(1,  "pd_walk_end",   4'b0100, 4'b0000, 1'b0, 4'b0000, 4'b0100, 2'd2);
    veh_req = 4'b0011;
    step(2,  "pd_yellow2",    4'b0000, 4'b0100, 1'b0, 4'b0000, 4'b0100, 2'd2);

    // Asynchronous reset in the middle of yellow.
    cyc(1);
    #2 reset = 1'b1;
    #1;
    expect_o("async_reset",   4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 2'd3);
    check_o();
    @(negedge clk);
    reset = 1'b0;
    step(2,  "rst_green0",    4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);

    // Freeze with tick low: lamps hold, ped request still latches.
    step(10, "fz_green10",    4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b0000, 2'd0);
    tick = 1'b0; ped_req = 4'b1000;
    cyc(1);
    ped_req = 4'b0000;
    step(49, "fz_frozen",     4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b1000, 2'd0);
    tick = 1'b1;
    step(21, "fz_green31",    4'b0001, 4'b0000, 1'b0, 4'b0000, 4'b1000, 2'd0);
    step(1,  "fz_yellow",     4'b0000, 4'b0001, 1'b0, 4'b0000, 4'b1000, 2'd0);
    step(4,  "fz_allred",     4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b1000, 2'd0);
    step(2,  "fz_green1",     4'b0010, 4'b0000, 1'b0, 4'b0000, 4'b1000, 2'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/intersection_phase_scheduler.md
Name: intersection_phase_scheduler

Overview:
Sequences a multi-approach intersection. It arbitrates vehicle and pedestrian requests from N approaches and grants one approach green at a time. Each green runs through yellow and an all-red clearance, with min-green, gap-out, max-out and walk timing. It sits above the per-approach traffic light controllers and drives their red/yellow/green/ped_walk lamp enables. All timing advances on a 1-cycle tick pulse from a shared prescaler.

Parameters:
N_APPR, 4, number of approaches (2..8)
MIN_GREEN, 8, minimum green dwell in ticks
MAX_GREEN, 32, green limit in ticks when other approaches are requesting
YELLOW_T, 4, yellow dwell in ticks
ALL_RED_T, 2, all-red clearance in ticks
WALK_T, 6, walk duration in ticks; must satisfy WALK_T <= MIN_GREEN
CW, 6, timer width; must hold MAX_GREEN

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
tick  in  1  timing enable, 1-cycle pulse
veh_req  in  N_APPR  level vehicle presence, one bit per approach
ped_req  in  N_APPR  pedestrian button pulses, one bit per approach
green  out  N_APPR  one-hot or zero green grant
yellow  out  N_APPR  one-hot or zero yellow
all_red  out  1  high in ALL_RED state
ped_walk  out  N_APPR  walk indication, at most one bit set
phase_idx  out  $clog2(N_APPR)  index of the current or last-served approach
ped_pend  out  N_APPR  latched pedestrian requests (status)

Behaviour:
- Reset (async, immediate):
  - state=ALL_RED, all_red=1, green/yellow/ped_walk/ped_pend=0.
  - Timer = ALL_RED_T; last-served pointer = N_APPR-1, so approach 0 has first priority; phase_idx=N_APPR-1.
- Timers and tick:
  - Timers move only when tick=1. With tick=0 all state and outputs freeze.
  - Requests are still sampled every clk while tick=0.
- States: ALL_RED, GREEN, YELLOW.
  - Each timed state dwells exactly its parameter count in ticks.
  - The transition takes effect on the clk edge of the expiring tick.
- Arbitration:
  - Request vector req = veh_req | ped_pend.
  - Round-robin search begins at (last+1) mod N_APPR.
- ALL_RED:
  - When the timer expires and req≠0: enter GREEN for the RR winner; phase_idx and last are updated to the winner.
  - When the timer has expired and req=0: rest in ALL_RED; the first tick with req≠0 enters GREEN.
- GREEN entry:
  - If ped_pend[w]=1: ped_walk[w]=1 for WALK_T ticks, and ped_pend[w] clears on the entry edge.
- GREEN, after MIN_GREEN ticks:
  - Others requesting (req & ~onehot(w) ≠ 0) and veh_req[w]=0: gap-out, go to YELLOW on the next tick.
  - Others requesting and veh_req[w]=1: extend until the total green reaches MAX_GREEN, then go to YELLOW (max-out).
  - No other requests: rest in green indefinitely; the green counter saturates.
- YELLOW: YELLOW_T ticks, then ALL_RED with timer = ALL_RED_T.
- Pedestrian latch:
  - ped_req sets ped_pend. If a set and a clear of the same bit coincide, the set wins.
  - ped_req for the currently green approach after GREEN entry stays pending and is served on its next green.
- Output invariants:
  - green and yellow are never both nonzero.
  - At most one bit of green or yellow is set.
  - ped_walk is a subset of green.
- Outputs are registered: lamps change on the same clk edge as the state.

Optional Feature:
Macro EMERGENCY_PREEMPT_EN.
- With it defined, two extra inputs exist: preempt (1 bit, level) and preempt_idx ($clog2(N_APPR) bits).
- While preempt=1:
  - A green on any approach other than preempt_idx goes to YELLOW on the next tick, ignoring MIN_GREEN, and ped_walk drops.
  - After ALL_RED, approach preempt_idx gets green and holds it while preempt=1, ignoring MAX_GREEN.
  - If preempt_idx is already green, it holds.
  - On release, normal operation resumes from GREEN of preempt_idx with its min-green already satisfied.
- Without the macro, the ports and logic are absent and behaviour is as specified above.

Decomposition:
- Package tlc_pkg holds:
  - the state enum (ST_ALL_RED, ST_GREEN, ST_YELLOW);
  - default timing constants;
  - a clog2 helper function.
- Sub-module rr_arbiter (parameter N): inputs req and last, output a one-hot grant plus index; purely combinational, with the pointer held in the parent.

Test Plan:
- Reset release, veh_req=4'b0010, tick every cycle → all_red for 2 ticks, then green=4'b0010; resting green persists beyond 32 ticks.
- veh_req=4'b0011 held → green 0001 for 32 ticks (max-out), then yellow 0001 for 4 ticks, all_red for 2 ticks, then green 0010.
- veh_req=4'b0011, bit 0 drops at green tick 10 → yellow 0001 on the next tick (gap-out, after MIN_GREEN=8 is satisfied).
- ped_req[2] pulses during approach 0 green, veh_req[2]=0 → ped_pend=4'b0100; approach 2 green with ped_walk=4'b0100 for 6 ticks; ped_pend clears on green entry.
- Reset asserted mid-YELLOW → all_red=1 and green/yellow/ped_walk/ped_pend=0 before the next clk edge; after release, approach 0 wins first.
- tick held at 0 for 50 cycles mid-green → outputs unchanged; the green count resumes exactly where it stopped.
